// File: rtl/stream_fork_dynamic.sv
// Forks one valid/ready handshake to a runtime-selected subset of output streams.
// Every selected output handshakes exactly once, and then the input is acknowledged.
module stream_fork_dynamic #(
  parameter int N_OUP = 32'd0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [N_OUP-1:0] sel_i,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  output logic [N_OUP-1:0] valid_o,
  input  logic [N_OUP-1:0] ready_i
);

  logic [N_OUP-1:0] done_q, done_d, hs;
  logic             act, all_done;

  always_comb begin
    // Outputs are forced low while reset is held, even though done_q is already clear.
    act     = valid_i & sel_valid_i & ~rst_i;
    valid_o = '0;
    for (int unsigned i = 0; i < $unsigned(N_OUP); i++) begin
      valid_o[i] = act & sel_i[i] & ~done_q[i];
    end
    hs          = valid_o & ready_i;
    all_done    = &(done_q | hs | ~sel_i);
    ready_o     = act & all_done;
    sel_ready_o = ready_o;
    done_d      = ready_o ? '0 : (done_q | hs);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  initial begin : p_n_oup_check
    assert (N_OUP >= 1)
      else $fatal(1, "stream_fork_dynamic: N_OUP must be at least 1");
  end

  sel_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (act && !ready_o) |=> $stable(sel_i))
    else $error("stream_fork_dynamic: sel_i changed during a pending transaction");

  valid_held_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> valid_i)
    else $error("stream_fork_dynamic: valid_i withdrawn before ready_o");

  no_valid_done_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(|(valid_o & done_q)))
    else $error("stream_fork_dynamic: valid_o raised on an output already served");
`endif
`endif

endmodule

// File: doc/stream_fork_dynamic.md
Name: stream_fork_dynamic

Overview:
Forks one input valid/ready handshake to a dynamically selected subset of N_OUP output streams. It is the fork-side counterpart of the dynamic stream join. Selected outputs may accept in different cycles; per-output completion flags ensure each selected output handshakes exactly once per input transaction. The input is acknowledged only once every selected output has handshaked. Data travels outside this block.

Parameters:
N_OUP, 32'd0, number of output streams; must be >= 1 (elaboration-time fatal otherwise).

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
valid_i  input  1  input stream valid
ready_o  output  1  input stream ready
sel_i  input  N_OUP  output selection mask for the current transaction
sel_valid_i  input  1  selection mask valid
sel_ready_o  output  1  selection mask ready; identical to ready_o
valid_o  output  N_OUP  per-output valid
ready_i  input  N_OUP  per-output ready

Behaviour:
- State: done_q[N_OUP], one flag per output, set once that output has handshaked in the current transaction. Resets to all 0.
- Transaction active: act = valid_i & sel_valid_i.
- valid_o[i] = act & sel_i[i] & ~done_q[i]. This is combinational. valid_o never depends on ready_i.
- Output handshake: hs[i] = valid_o[i] & ready_i[i].
- all_done = &(done_q | hs | ~sel_i).
- ready_o = sel_ready_o = act & all_done. There is a combinational path from ready_i to ready_o; this is allowed by the protocol.
- Next state:
  - If ready_o, done_d = 0 (transaction retires; next transaction starts clean).
  - Otherwise, done_d = done_q | hs.
  - Flags of unselected outputs never set.
- Latency: zero-cycle pass-through when all selected outputs are ready. A transaction takes 1 cycle minimum; otherwise it retires in the cycle the last selected output handshakes.
- Back-to-back: a new transaction may be presented in the cycle after ready_o without bubbles.
- sel_i all 0s with act: ready_o = 1 in the same cycle; valid_o = 0; done_q unchanged (remains 0).
- Single selected bit: behaves as a plain pass-through, with ready_o = ready_i[k] & act.
- An output that has handshaked keeps valid_o[i] = 0 for the rest of the transaction, even if the input stays valid.
- Protocol obligations on upstream (asserted in simulation, not handled in RTL):
  - Once act is asserted, valid_i, sel_valid_i and sel_i stay stable until ready_o.
  - valid_i and sel_valid_i may not be withdrawn before ready_o.
- Output protocol: valid_o[i], once asserted, stays asserted until hs[i], given upstream obeys the above.
- Reset mid-transaction:
  - done_q clears asynchronously; valid_o and ready_o are 0 while rst_i = 1.
  - After release, if act persists, all selected outputs are re-offered, including those already handshaked. Callers must reset upstream and downstream together.
- Simulation assertions (guarded by SYNTHESIS and COMMON_CELLS_ASSERTS_OFF):
  - N_OUP >= 1.
  - sel_i stable while act & ~ready_o.
  - valid_i held until ready_o.
  - No valid_o[i] while done_q[i].

Test Plan:
All scenarios use N_OUP = 4.
1. Reset: hold rst_i = 1 with valid_i = sel_valid_i = 1, sel_i = 4'b1111 -> valid_o = 4'b0000, ready_o = 0. Release -> valid_o = 4'b1111 in the same cycle.
2. All ready: sel_i = 4'b1011, ready_i = 4'b1111, act = 1 -> valid_o = 4'b1011 and ready_o = 1 in cycle 0; done_q = 0 in cycle 1.
3. Staggered accept: sel_i = 4'b1011; ready_i = 4'b0001, then 4'b0010, then 4'b1000 over cycles 0-2 ->
   - valid_o = 4'b1011, 4'b1010, 4'b1000;
   - ready_o = 0, 0, 1;
   - each of outputs 0, 1, 3 handshakes exactly once.
4. Empty select: sel_i = 4'b0000, act = 1 -> ready_o = sel_ready_o = 1 in the same cycle; valid_o = 4'b0000.
5. Back-to-back: cycle 0 sel_i = 4'b0011 with all ready; cycle 1 sel_i = 4'b1100 with ready_i = 4'b0100, then 4'b1000 ->
   - ready_o = 1 in cycles 0 and 2;
   - valid_o = 4'b1100, 4'b1000 in cycles 1 and 2;
   - no handshake bleeds across transactions.
6. Reset mid-transaction: sel_i = 4'b0110; output 1 handshakes in cycle 0; assert rst_i in cycle 1; release in cycle 2 with act held -> valid_o = 4'b0110 in cycle 2 (output 1 re-offered).
